// File: rtl/mpram_write_sched_if.sv
// mpram_write_sched_if: requester handshake and RAM write-port bundle for mpram_write_sched
interface mpram_write_sched_if #(
  parameter int BLOCKSIZE = 10,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*(BLOCKSIZE+1)-1:0] req_addr;
  logic [NREQ*32-1:0] req_data;
  logic clear_req;
  logic init_done;
  logic [BLOCKSIZE:0] w1_addr;
  logic [31:0] w1_din;
  logic en_w1;
  modport master (
    output req_valid, req_addr, req_data, clear_req,
    input req_ready, init_done, w1_addr, w1_din, en_w1
  );
  modport slave (
    input req_valid, req_addr, req_data, clear_req,
    output req_ready, init_done, w1_addr, w1_din, en_w1
  );
endinterface

// File: rtl/mpram_write_sched.sv
// mpram_write_sched: round-robin write-port scheduler with zero sweep; sweep enabled by MPRAM_INIT_CLEAR_EN
module mpram_write_sched #(
  parameter int BLOCKSIZE = 10,
  parameter int NREQ = 4
) (
  input logic clk,
  input logic rst,
  mpram_write_sched_if.slave bus
);
  localparam int AW = BLOCKSIZE + 1;
  localparam int PW = $clog2(NREQ);
`ifdef MPRAM_INIT_CLEAR_EN
  typedef enum logic {INIT, ARB} state_t;
`else
  typedef enum logic {PEND, ARB} state_t;
`endif
  state_t state;
  logic [PW-1:0] ptr, win, nxt;
  logic [PW:0] sum, idx;
  logic found, accept, clr;
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(NREQ)) ? sum - (PW+1)'(NREQ) : sum;
      if (!found && bus.req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        win = idx[PW-1:0];
      end
    end
  end
`ifdef MPRAM_INIT_CLEAR_EN
  assign clr = bus.clear_req;
`else
  logic unused_clear;
  assign unused_clear = bus.clear_req;
  assign clr = 1'b0;
`endif
  // ready is suppressed during a clear cycle so no write races the sweep restart
  assign bus.req_ready = (!rst && state == ARB && !clr && found) ? NREQ'(1) << win : '0;
  assign accept = |bus.req_ready;
  assign bus.init_done = state == ARB;
  assign nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef MPRAM_INIT_CLEAR_EN
  logic [AW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      ptr <= '0;
      bus.en_w1 <= 1'b0;
      bus.w1_addr <= '0;
      bus.w1_din <= '0;
    end else if (state == INIT) begin
      bus.en_w1 <= 1'b1;
      bus.w1_addr <= cnt;
      bus.w1_din <= '0;
      cnt <= cnt + 1'b1;
      if (&cnt) state <= ARB;
    end else if (clr) begin
      state <= INIT;
      cnt <= '0;
      bus.en_w1 <= 1'b0;
    end else begin
      bus.en_w1 <= accept;
      if (accept) begin
        bus.w1_addr <= bus.req_addr[int'(win)*AW +: AW];
        bus.w1_din <= bus.req_data[int'(win)*32 +: 32];
        ptr <= nxt;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PEND;
      ptr <= '0;
      bus.en_w1 <= 1'b0;
      bus.w1_addr <= '0;
      bus.w1_din <= '0;
    end else begin
      state <= ARB;
      bus.en_w1 <= accept;
      if (accept) begin
        bus.w1_addr <= bus.req_addr[int'(win)*AW +: AW];
        bus.w1_din <= bus.req_data[int'(win)*32 +: 32];
        ptr <= nxt;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mpram_write_sched.sv
// tb_mpram_write_sched: randomized bench for mpram_write_sched against a queue-free behavioural model
module tb_mpram_write_sched;
  localparam int BS = 10;
  localparam int N = 4;
  localparam int DEPTH = 2 << BS;
`ifdef MPRAM_INIT_CLEAR_EN
  localparam bit ON = 1'b1;
`else
  localparam bit ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mpram_write_sched_if #(.BLOCKSIZE(BS), .NREQ(N)) bus();
  mpram_write_sched #(.BLOCKSIZE(BS), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  bit v [N];
  logic [BS:0] a [N];
  logic [31:0] d [N];
  bit clr;
  bit m_arb;
  int m_cnt, m_ptr;
  logic e_en;
  logic [BS:0] e_addr;
  logic [31:0] e_din;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = v[i];
      bus.req_addr[i*(BS+1) +: BS+1] = a[i];
      bus.req_data[i*32 +: 32] = d[i];
    end
    bus.clear_req = clr;
  endtask
  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  task automatic cyc(input int pnew);
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g = (!rst && m_arb && !(ON && clr)) ? pick() : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("init_done", bus.init_done, m_arb);
    @(posedge clk);
    #1;
    if (rst) begin
      m_arb = 0; m_cnt = 0; m_ptr = 0; e_en = 0; e_addr = 0; e_din = 0;
    end else if (!m_arb) begin
      if (ON) begin
        e_en = 1; e_addr = m_cnt[BS:0]; e_din = 0;
        m_arb = (m_cnt == DEPTH - 1);
        m_cnt++;
      end else begin
        e_en = 0; m_arb = 1;
      end
    end else if (ON && clr) begin
      m_arb = 0; m_cnt = 0; e_en = 0;
    end else if (g >= 0) begin
      e_en = 1; e_addr = a[g]; e_din = d[g];
      m_ptr = (g + 1) % N;
      v[g] = 0;
    end else begin
      e_en = 0;
    end
    chk("en_w1", bus.en_w1, e_en);
    chk("w1_addr", bus.w1_addr, e_addr);
    chk("w1_din", bus.w1_din, e_din);
    clr = 0;
    for (int i = 0; i < N; i++)
      if (!v[i] && $urandom_range(99) < pnew) begin
        v[i] = 1; a[i] = $urandom; d[i] = $urandom;
      end
    drive();
  endtask
  task automatic to_arb();
    for (int t = 0; t < DEPTH + 4 && !m_arb; t++) cyc(0);
    chk("reach_arb", bus.init_done, 1);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    m_arb = 0; m_cnt = 0; m_ptr = 0; e_en = 0; e_addr = 0; e_din = 0; clr = 0;
    for (int i = 0; i < N; i++) begin
      v[i] = 0; a[i] = 0; d[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1; a[i] = $urandom; d[i] = $urandom;
    end
    drive();
    repeat (2) cyc(0);
    rst = 0;
    to_arb();
    repeat (N + 1) cyc(0);
    v[2] = 1; a[2] = 5; d[2] = 32'h2A;
    drive();
    cyc(0);
    chk("req2_addr", bus.w1_addr, 5);
    chk("req2_din", bus.w1_din, 32'h2A);
    cyc(0);
    chk("req2_idle", bus.en_w1, 0);
    v[3] = 1; a[3] = 2047; d[3] = 32'hFF;
    drive();
    cyc(0);
    chk("req3_addr", bus.w1_addr, 2047);
    chk("req3_din", bus.w1_din, 32'hFF);
    for (int i = 0; i < N; i++) begin
      v[i] = 1; a[i] = $urandom; d[i] = $urandom;
    end
    drive();
    repeat (8) cyc(100);
    repeat (N + 1) cyc(0);
    v[1] = 1; a[1] = $urandom; d[1] = $urandom;
    clr = 1;
    drive();
    cyc(0);
    to_arb();
    cyc(0);
    clr = 1;
    drive();
    cyc(0);
    for (int t = 0; t < 200 && !(e_en === 1'b1 && e_addr == 100); t++) cyc(0);
    rst = 1;
    drive();
    cyc(0);
    rst = 0;
    to_arb();
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(399) == 0) clr = 1;
      drive();
      cyc(40);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mpram_write_sched.md
Name: mpram_write_sched

Overview:
- Write-side scheduler for the replicated-bank multi-port RAM (16 read ports, 1 write port `w1`).
- Shares the single write port among NREQ independent writers using valid/ready handshakes and round-robin arbitration.
- Sequences a full-memory zero sweep after reset and on request, so the read replicas start with identical contents.
- Sits directly in front of the RAM's `w1_addr`, `w1_din` and `en_w1` inputs.

Parameters:
- BLOCKSIZE, 10, RAM address width is BLOCKSIZE+1 bits; depth is 2<<BLOCKSIZE (2048).
- NREQ, 4, number of write requesters (2..8).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*(BLOCKSIZE+1)  packed addresses; requester i at slice [i*(BLOCKSIZE+1) +: BLOCKSIZE+1].
- req_data  input  NREQ*32  packed write data; requester i at [i*32 +: 32].
- req_ready  output  NREQ  one-hot or zero; handshake completes when req_valid[i] & req_ready[i].
- clear_req  input  1  one-cycle pulse; re-runs the zero sweep.
- init_done  output  1  high when the scheduler is in ARB state.
- w1_addr  output  BLOCKSIZE+1  RAM write address, registered.
- w1_din  output  32  RAM write data, registered.
- en_w1  output  1  RAM write enable, registered.

Behaviour:
- Reset (rst=1 at posedge):
  - en_w1=0, w1_addr=0, w1_din=0, init_done=0.
  - Round-robin pointer=0, sweep counter=0.
  - State=INIT (feature on) or ARB-pending (feature off).
  - req_ready=0 while rst=1.
- States: INIT (zero sweep) and ARB (arbitration).
- INIT state:
  - Each cycle, registers en_w1=1, w1_addr=counter, w1_din=0; counter increments by 1.
  - When counter = (2<<BLOCKSIZE)-1 is loaded, the same edge moves to ARB and sets init_done=1.
  - Sweep occupies exactly 2<<BLOCKSIZE cycles (2048 by default); req_ready=0 throughout.
- ARB state:
  - req_ready is combinational: one-hot to the first valid requester scanning from pointer upward, modulo NREQ.
  - req_ready=0 if no req_valid is set.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- Accept at posedge E:
  - Registers en_w1=1, w1_addr/w1_din from the winner.
  - Pointer becomes (winner+1) mod NREQ.
  - RAM commits the write at posedge E+1.
  - Latency from handshake to en_w1 visible: 1 cycle.
- No accept at an edge: en_w1=0; w1_addr/w1_din hold their previous values.
- Throughput: one write per cycle; no internal buffering.
- Pointer does not move on idle cycles.
- Non-winning requesters must hold valid/addr/data stable until accepted.
- clear_req:
  - Sampled only in ARB.
  - With clear_req=1, all req_ready=0 that cycle; no accept.
  - Next edge: state=INIT, counter=0, init_done=0, en_w1=0 for that cycle.
  - Sweep starts at the following edge.
  - clear_req during INIT is ignored; the sweep does not restart.
- A handshake in the cycle init_done first rises is legal. Its write follows the addr-2047 sweep write, preserving order.
- rst asserted mid-sweep or mid-arbitration aborts immediately to reset values. No partial write is issued after the reset edge.
- Address/data pass through unmodified; no width conversion.

Optional Feature:
- Macro: MPRAM_INIT_CLEAR_EN.
- Defined:
  - INIT state and zero sweep exist as above.
  - Reset enters INIT; clear_req functional.
- Undefined:
  - No INIT state or sweep counter.
  - First posedge with rst=0 sets init_done=1 and arbitration begins the following cycle.
  - clear_req is ignored.
  - en_w1 stays 0 until the first handshake.

Test Plan:
- Reset release (macro on) -> en_w1=1 for 2048 consecutive cycles, w1_addr 0..2047, w1_din=0, then init_done=1; req_ready=0 throughout sweep.
- Single requester 2 issues addr=5, data=0x2A after init -> req_ready=4'b0100 same cycle; next cycle en_w1=1, w1_addr=5, w1_din=0x2A; one cycle later en_w1=0.
- All 4 valid continuously, pointer=0 -> grants 0,1,2,3,0 on consecutive cycles; en_w1 high every cycle.
- clear_req pulsed while requester 1 valid -> req_ready=0 that cycle; init_done falls next edge; sweep of 2048 writes follows; requester 1 is granted on the first ARB cycle.
- rst asserted at sweep address 100 -> en_w1=0 and init_done=0 next cycle; after release, sweep restarts at addr 0.
- Macro off, reset release -> init_done=1 after one cycle, no sweep writes; requester 3 write addr=2047, data=0xFF appears on w1 one cycle after its handshake.
